pulse_seq_detector: RTL and testbench

Clocked, parametrised successor to the lab's asynchronous two-input pulse-sequence circuit. It detects one x1 pulse followed by SEQ_LEN consecutive x2 pulses and then asserts z. Raw x1/x2 are slow, level-held pulse inputs from switches or buttons, so the block synchronises and edge-detects them. It also counts detections and flags illegal simultaneous pulses, making it a drop-in sequence detector for EGO1 board exercises.

---
 rtl/pulse_seq_detector.sv | 115 +++++++++++
 tb/tb_pulse_seq_detector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_detector.sv
// Clocked pulse-sequence detector: one x1 pulse then SEQ_LEN x2 pulses asserts z.
// Raw inputs are synchronised and rising-edge detected; detections are counted and clashes flagged.
module pulse_seq_detector #(
  parameter int unsigned SEQ_LEN     = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned Z_MODE      = 0
) (
  input  logic             clk,
  input  logic             rd,
  input  logic             x1,
  input  logic             x2,
  input  logic             clr,
  output logic             z,
  output logic             armed,
  output logic [3:0]       x2_cnt,
  output logic [CNT_W-1:0] det_cnt,
  output logic             err
);

  generate
    if (SEQ_LEN == 0 || SEQ_LEN > 15) begin : g_bad_seq_len
      $fatal(1, "pulse_seq_detector: SEQ_LEN=%0d outside 1..15", SEQ_LEN);
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "pulse_seq_detector: SYNC_STAGES=%0d below 2", SYNC_STAGES);
    end
  endgenerate

  localparam logic [4:0]       LAST_CNT = 5'(SEQ_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync1;
  logic [SYNC_STAGES-1:0] sync2;
  logic                   hist1;
  logic                   hist2;
  logic                   p1;
  logic                   p2;
  logic                   both_c;
  logic                   hit_c;

  // Synchronisers, edge history and registered one-cycle strobes.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      sync1 <= '0;
      sync2 <= '0;
      hist1 <= 1'b0;
      hist2 <= 1'b0;
      p1    <= 1'b0;
      p2    <= 1'b0;
    end else begin
      sync1 <= {sync1[SYNC_STAGES-2:0], x1};
      sync2 <= {sync2[SYNC_STAGES-2:0], x2};
      hist1 <= sync1[SYNC_STAGES-1];
      hist2 <= sync2[SYNC_STAGES-1];
      p1    <= sync1[SYNC_STAGES-1] & ~hist1;
      p2    <= sync2[SYNC_STAGES-1] & ~hist2;
    end
  end

  assign both_c = p1 & p2;
  assign hit_c  = (state == ARMED) & p2 & ~p1 & (({1'b0, x2_cnt} + 5'd1) == LAST_CNT);
  assign armed  = (state == ARMED);

  // Sequence state machine with registered z, counters and error flag.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      state   <= IDLE;
      x2_cnt  <= 4'd0;
      det_cnt <= '0;
      err     <= 1'b0;
      z       <= 1'b0;
    end else begin
      if (both_c) begin
        state  <= IDLE;
        x2_cnt <= 4'd0;
      end else if (p1) begin
        state  <= ARMED;
        x2_cnt <= 4'd0;
      end else if (p2 && state == ARMED) begin
        if (hit_c) begin
          state  <= IDLE;
          x2_cnt <= 4'd0;
        end else begin
          x2_cnt <= x2_cnt + 4'd1;
        end
      end

      if (clr)
        err <= 1'b0;
      else if (both_c)
        err <= 1'b1;

      // clr wins over a coincident detection, so that detection is not counted.
      if (clr)
        det_cnt <= '0;
      else if (hit_c && det_cnt != CNT_MAX)
        det_cnt <= det_cnt + CNT_W'(1);

      // Held z drops on any later strobe unless that strobe itself detects.
      if (Z_MODE == 0)
        z <= hit_c;
      else if (clr)
        z <= 1'b0;
      else if (hit_c)
        z <= 1'b1;
      else if (p1 || p2)
        z <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_seq_detector.sv
// Scoreboard bench for pulse_seq_detector: stimulus queues expected output snapshots,
// per-instance monitors compare them against every observed output change.
module tb_pulse_seq_detector;

  logic       clk = 1'b0;
  logic       rd  = 1'b0;
  logic       clr = 1'b0;
  logic       xa1 = 1'b0, xa2 = 1'b0, xb1 = 1'b0, xb2 = 1'b0;
  logic       za, arma, erra, zb, armb, errb;
  logic [3:0] x2a, x2b;
  logic [1:0] deta;
  logic [7:0] detb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  typedef struct {
    int          cyc;
    logic [14:0] v;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [14:0] prev_a = '0;
  logic [14:0] prev_b = '0;

  // Instance a: SEQ_LEN 2, 2-bit counter, pulsed z.
  pulse_seq_detector #(.SEQ_LEN(2), .CNT_W(2), .SYNC_STAGES(2), .Z_MODE(0)) dut_a (
    .clk(clk), .rd(rd), .x1(xa1), .x2(xa2), .clr(clr),
    .z(za), .armed(arma), .x2_cnt(x2a), .det_cnt(deta), .err(erra)
  );

  // Instance b: SEQ_LEN 3, held z.
  pulse_seq_detector #(.SEQ_LEN(3), .CNT_W(8), .SYNC_STAGES(2), .Z_MODE(1)) dut_b (
    .clk(clk), .rd(rd), .x1(xb1), .x2(xb2), .clr(clr),
    .z(zb), .armed(armb), .x2_cnt(x2b), .det_cnt(detb), .err(errb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] mk(logic zz, logic aa, int x2, int det, logic ee);
    return {zz, aa, 4'(x2), 8'(det), ee};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input bit sel, input int dc, input logic [14:0] v);
    exp_t e;
    e.cyc = t0 + dc;
    e.v   = v;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  // One 20-clock pulse with 20-clock gap; n expected changes at +4 (and +5).
  task automatic pulse(input bit sel, input logic v1, input logic v2, input int n,
                       input logic [14:0] e4, input logic [14:0] e5);
    @(negedge clk);
    t0 = cyc;
    if (sel) begin xb1 = v1; xb2 = v2; end
    else     begin xa1 = v1; xa2 = v2; end
    if (n > 0) push(sel, 4, e4);
    if (n > 1) push(sel, 5, e5);
    repeat (20) @(negedge clk);
    xa1 = 1'b0; xa2 = 1'b0; xb1 = 1'b0; xb2 = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic clr_pulse(input bit sel, input logic [14:0] e1);
    @(negedge clk);
    t0  = cyc;
    clr = 1'b1;
    push(sel, 1, e1);
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic rst_pulse;
    @(posedge clk);
    #2 rd = 1'b0;
    @(posedge clk);
    #2 rd = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [14:0] cur;
    exp_t        e;
    cur = {za, arma, x2a, 8'(deta), erra};
    if (!rd) prev_a = '0;
    else if (cur !== prev_a) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected at cyc %0d: got %0h want %0h", cyc, cur, prev_a);
      end else begin
        e = qa.pop_front();
        chk("a_outputs", 32'(cur), 32'(e.v));
        chk("a_cycle", cyc, e.cyc);
      end
      prev_a = cur;
    end
  end

  always @(negedge clk) begin
    logic [14:0] cur;
    exp_t        e;
    cur = {zb, armb, x2b, detb, errb};
    if (!rd) prev_b = '0;
    else if (cur !== prev_b) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected at cyc %0d: got %0h want %0h", cyc, cur, prev_b);
      end else begin
        e = qb.pop_front();
        chk("b_outputs", 32'(cur), 32'(e.v));
        chk("b_cycle", cyc, e.cyc);
      end
      prev_b = cur;
    end
  end

  initial begin
    int d0, d1;
    repeat (3) @(negedge clk);
    chk("reset_a", {za, arma, x2a, deta, erra}, 0);
    chk("reset_b", {zb, armb, x2b, detb, errb}, 0);
    @(posedge clk);
    #2 rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_release_a", {za, arma, x2a, deta, erra}, 0);

    // Basic x1, x2, x2 detection.
    pulse(0, 1, 0, 1, mk(0, 1, 0, 0, 0), '0);
    pulse(0, 0, 1, 1, mk(0, 1, 1, 0, 0), '0);
    pulse(0, 0, 1, 2, mk(1, 0, 0, 1, 0), mk(0, 0, 0, 1, 0));

    // Restart, overlap rule and re-arm.
    rst_pulse();
    pulse(0, 1, 0, 1, mk(0, 1, 0, 0, 0), '0);
    pulse(0, 0, 1, 1, mk(0, 1, 1, 0, 0), '0);
    pulse(0, 1, 0, 1, mk(0, 1, 0, 0, 0), '0);
    pulse(0, 0, 1, 1, mk(0, 1, 1, 0, 0), '0);
    pulse(0, 0, 1, 2, mk(1, 0, 0, 1, 0), mk(0, 0, 0, 1, 0));
    pulse(0, 0, 1, 0, '0, '0);
    pulse(0, 1, 0, 1, mk(0, 1, 0, 1, 0), '0);

    // Simultaneous pulses while armed: sticky err, cleared by clr.
    pulse(0, 0, 1, 1, mk(0, 1, 1, 1, 0), '0);
    pulse(0, 1, 1, 1, mk(0, 0, 0, 1, 1), '0);
    pulse(0, 1, 0, 1, mk(0, 1, 0, 1, 1), '0);
    clr_pulse(0, mk(0, 1, 0, 0, 0));

    // Counter saturation on a 2-bit det_cnt.
    rst_pulse();
    for (int k = 1; k <= 5; k++) begin
      d0 = (k - 1 > 3) ? 3 : k - 1;
      d1 = (k > 3) ? 3 : k;
      pulse(0, 1, 0, 1, mk(0, 1, 0, d0, 0), '0);
      pulse(0, 0, 1, 1, mk(0, 1, 1, d0, 0), '0);
      pulse(0, 0, 1, 2, mk(1, 0, 0, d1, 0), mk(0, 0, 0, d1, 0));
    end

    // clr coincident with a detection: not counted, z still pulses.
    pulse(0, 1, 0, 1, mk(0, 1, 0, 3, 0), '0);
    pulse(0, 0, 1, 1, mk(0, 1, 1, 3, 0), '0);
    @(negedge clk);
    t0  = cyc;
    xa2 = 1'b1;
    push(0, 4, mk(1, 0, 0, 0, 0));
    push(0, 5, mk(0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (20) @(negedge clk);
    xa2 = 1'b0;
    repeat (20) @(negedge clk);

    // Held z with SEQ_LEN 3: dropped by the next strobe, then by clr.
    rst_pulse();
    pulse(1, 1, 0, 1, mk(0, 1, 0, 0, 0), '0);
    pulse(1, 0, 1, 1, mk(0, 1, 1, 0, 0), '0);
    pulse(1, 0, 1, 1, mk(0, 1, 2, 0, 0), '0);
    pulse(1, 0, 1, 1, mk(1, 0, 0, 1, 0), '0);
    pulse(1, 1, 0, 1, mk(0, 1, 0, 1, 0), '0);
    pulse(1, 0, 1, 1, mk(0, 1, 1, 1, 0), '0);
    pulse(1, 0, 1, 1, mk(0, 1, 2, 1, 0), '0);
    pulse(1, 0, 1, 1, mk(1, 0, 0, 2, 0), '0);
    clr_pulse(1, mk(0, 0, 0, 0, 0));

    // Asynchronous reset mid-sequence, then x2 alone must do nothing.
    rst_pulse();
    pulse(0, 1, 0, 1, mk(0, 1, 0, 0, 0), '0);
    pulse(0, 0, 1, 1, mk(0, 1, 1, 0, 0), '0);
    @(negedge clk);
    rd = 1'b0;
    #1;
    chk("async_reset_a", {za, arma, x2a, deta, erra}, 0);
    @(posedge clk);
    #2 rd = 1'b1;
    repeat (3) @(negedge clk);
    pulse(0, 0, 1, 0, '0, '0);
    chk("x2_alone_armed", arma, 0);
    pulse(0, 1, 0, 1, mk(0, 1, 0, 0, 0), '0);

    repeat (10) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
